// File: rtl/scrambler_pkg.sv
// Shared definitions for the scrambler engine: FSM encoding, LFSR polynomial
// and the Galois step function used by the LFSR stage.
package scrambler_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_GEN   = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_SWAP  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // x^16+x^14+x^13+x^11+1 in right-shifting Galois form
    localparam logic [15:0] LFSR_MASK  = 16'hB400;
    localparam int          LFSR_MAX_W = 32;

    // Operands narrower than LFSR_MAX_W must be zero-extended; the upper bits stay zero.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_step(
        input logic [LFSR_MAX_W-1:0] cur,
        input logic [LFSR_MAX_W-1:0] mask
    );
        return (cur >> 1) ^ (cur[0] ? mask : '0);
    endfunction

endpackage

// File: rtl/scrambler_engine_lfsr.sv
// Galois LFSR stage: loads a seed (0 forced to 1), advances one step on request.
module lfsr_galois
    import scrambler_pkg::*;
#(
    parameter int              LFSR_W = 16,
    parameter logic [LFSR_W-1:0] MASK = LFSR_W'(LFSR_MASK)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] seed,
    input  logic              advance,
    output logic [LFSR_W-1:0] state
);

    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_W'(1);
        end else if (load) begin
            state <= (seed == '0) ? LFSR_W'(1) : seed;
        end else if (advance) begin
            state <= LFSR_W'(lfsr_step(LFSR_MAX_W'(state), LFSR_MAX_W'(MASK)));
        end
    end

endmodule

// File: rtl/scrambler_engine.sv
// In-place Fisher-Yates scrambler over a DEPTH x DATA_W regfile; mode 1 replays
// the same swap sequence backwards to undo a scramble made with the same seed.
module scrambler_engine
    import scrambler_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int LFSR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W:0]   len,
    input  logic [LFSR_W-1:0] seed,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_din,
    output logic [DATA_W-1:0] host_rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int              DEPTH   = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0] TWO_L   = (ADDR_W+1)'(2);

    logic [2:0]          state_q;
    logic                mode_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   i_q;
    logic [ADDR_W-1:0]   j_q;
    logic [DATA_W-1:0]   temp_q;
    logic                err_q;

    logic [DATA_W-1:0]   mem  [DEPTH];
    logic [ADDR_W-1:0]   jlog [DEPTH];

    logic [LFSR_W-1:0]   lfsr_state;
    logic                len_ok;
    logic                lfsr_load;
    logic                lfsr_adv;
    logic                last_i;
    logic [ADDR_W:0]     range_r;
    logic [2*ADDR_W:0]   prod;
    logic [ADDR_W-1:0]   j_rand;

    assign len_ok    = (len != '0) && (len <= DEPTH_L);
    assign lfsr_load = (state_q == S_IDLE) && start && len_ok;
    assign lfsr_adv  = (state_q == S_GEN) || ((state_q == S_READ) && !mode_q);
    assign last_i    = ({1'b0, i_q} == len_q - TWO_L);

    // Multiply-shift maps the low LFSR bits onto [0, len-i) without a divider.
    assign range_r = len_q - {1'b0, i_q};
    assign prod    = (2*ADDR_W+1)'(ADDR_W'(lfsr_state)) * (2*ADDR_W+1)'(range_r);
    assign j_rand  = i_q + ADDR_W'(prod >> ADDR_W);

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = err_q;
    assign host_rdata = mem[host_addr];

    lfsr_galois #(
        .LFSR_W (LFSR_W),
        .MASK   (LFSR_W'(LFSR_MASK))
    ) u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .load    (lfsr_load),
        .seed    (seed),
        .advance (lfsr_adv),
        .state   (lfsr_state)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            err_q   <= 1'b0;
            mode_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (!len_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q <= mode;
                            len_q  <= len;
                            i_q    <= '0;
                            if (len == ONE_L)  state_q <= S_DONE;
                            else if (mode)     state_q <= S_GEN;
                            else               state_q <= S_READ;
                        end
                    end
                end
                S_GEN: begin
                    if (last_i) state_q <= S_READ;
                    else        i_q     <= i_q + ADDR_W'(1);
                end
                S_READ:  state_q <= S_SWAP;
                S_SWAP:  state_q <= S_WRITE;
                S_WRITE: begin
                    if (!mode_q) begin
                        i_q     <= i_q + ADDR_W'(1);
                        state_q <= last_i ? S_DONE : S_READ;
                    end else if (i_q == '0) begin
                        state_q <= S_DONE;
                    end else begin
                        i_q     <= i_q - ADDR_W'(1);
                        state_q <= S_READ;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: regfile, jlog and datapath registers carry no reset; they are storage, not control.
    always_ff @(posedge clk) begin
        if (!reset && state_q == S_READ) begin
            temp_q <= mem[i_q];
            j_q    <= mode_q ? jlog[i_q] : j_rand;
        end
        if (!reset && state_q == S_GEN) begin
            jlog[i_q] <= j_rand;
        end
        if (!reset && state_q == S_SWAP) begin
            mem[i_q] <= mem[j_q];
        end else if (!reset && state_q == S_WRITE) begin
            mem[j_q] <= temp_q;
        end else if (host_we && !busy) begin
            mem[host_addr] <= host_din;
        end
    end

endmodule

// File: tb/tb_scrambler_engine.sv
// Directed bench for scrambler_engine: hand-derived permutations, cycle counts,
// illegal starts, seed 0 handling, mid-run reset and busy-time interference.
module tb_scrambler_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [4:0]  len;
    logic [15:0] seed;
    logic        host_we;
    logic [3:0]  host_addr;
    logic [7:0]  host_din;
    logic [7:0]  host_rdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc;

    // Golden permutations, worked out by hand from the LFSR sequence.
    logic [7:0] ident_hi [16] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                                  8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F};
    logic [7:0] exp1     [16] = '{8'h00, 8'h01, 8'h05, 8'h06, 8'h07, 8'h03, 8'h02, 8'h04,
                                  8'h88, 8'h89, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 8'h8E, 8'h8F};
    logic [7:0] ident16  [16] = '{8'd0, 8'd1, 8'd2,  8'd3,  8'd4,  8'd5,  8'd6,  8'd7,
                                  8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15};
    logic [7:0] exp4     [16] = '{8'd1,  8'd0,  8'd2,  8'd3,  8'd4,  8'd5,  8'd6,  8'd7,
                                  8'd12, 8'd10, 8'd13, 8'd15, 8'd9,  8'd11, 8'd14, 8'd8};

    always #5 clk = ~clk;

    scrambler_engine #(
        .DATA_W (8),
        .ADDR_W (4),
        .LFSR_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .len        (len),
        .seed       (seed),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_din   (host_din),
        .host_rdata (host_rdata),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        host_we   = 1'b1;
        host_addr = a;
        host_din  = d;
        @(posedge clk);
        #1;
        host_we = 1'b0;
    endtask

    // Entries 0..7 get k, entries 8..15 get hi_base+k.
    task automatic load_mem(input logic [7:0] hi_base);
        for (int k = 0; k < 16; k++) begin
            host_write(4'(k), (k < 8) ? 8'(k) : 8'(hi_base + 8'(k)));
        end
    endtask

    task automatic expect_mem(input string tag, input logic [7:0] exp [16]);
        for (int k = 0; k < 16; k++) begin
            host_addr = 4'(k);
            #1;
            check($sformatf("%s_mem%0d", tag, k), {24'd0, host_rdata}, {24'd0, exp[k]});
        end
    endtask

    // Starts one operation and counts cycles until done; with inject set, a host
    // write to addr 3 and a conflicting start are pulsed while the engine is busy.
    task automatic run_op(input logic m, input logic [4:0] l, input logic [15:0] s,
                          input bit inject, output int cycles);
        mode  = m;
        len   = l;
        seed  = s;
        start = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 200) begin
            if (inject && cycles == 4) begin
                host_we   = 1'b1;
                host_addr = 4'd3;
                host_din  = 8'hEE;
                start     = 1'b1;
                mode      = ~m;
                len       = 5'd3;
                seed      = 16'h1234;
            end else begin
                host_we = 1'b0;
                start   = 1'b0;
                mode    = m;
                len     = l;
                seed    = s;
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        host_we = 1'b0;
        start   = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        mode      = 1'b0;
        len       = '0;
        seed      = '0;
        host_we   = 1'b0;
        host_addr = '0;
        host_din  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err",  err,  0);
        reset = 1'b0;

        // 1: scramble 8 entries, upper half untouched
        load_mem(8'h80);
        run_op(1'b0, 5'd8, 16'hACE1, 1'b0, cyc);
        check("t1_cycles", cyc, 22);
        check("t1_busy_after", busy, 0);
        expect_mem("t1", exp1);

        // 2: unscramble restores the original
        run_op(1'b1, 5'd8, 16'hACE1, 1'b0, cyc);
        check("t2_cycles", cyc, 29);
        expect_mem("t2", ident_hi);

        // 3: len=1 is a no-op; illegal lengths only pulse err
        run_op(1'b0, 5'd1, 16'h5555, 1'b0, cyc);
        check("t3_len1_cycles", cyc, 1);
        expect_mem("t3", ident_hi);
        for (int t = 0; t < 2; t++) begin
            mode  = 1'b0;
            len   = (t == 0) ? 5'd0 : 5'd17;
            seed  = 16'h0001;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check($sformatf("t3_err_len%0d", len), err, 1);
            check($sformatf("t3_busy_len%0d", len), busy, 0);
            @(posedge clk);
            #1;
            check($sformatf("t3_err_clear_len%0d", len), err, 0);
            check($sformatf("t3_idle_len%0d", len), busy, 0);
        end
        expect_mem("t3_err", ident_hi);

        // 4: full depth, seed 1 and seed 0 must match
        load_mem(8'h00);
        run_op(1'b0, 5'd16, 16'h0001, 1'b0, cyc);
        check("t4_s1_cycles", cyc, 46);
        expect_mem("t4_s1", exp4);
        run_op(1'b1, 5'd16, 16'h0001, 1'b0, cyc);
        check("t4_s1_inv_cycles", cyc, 61);
        expect_mem("t4_s1_inv", ident16);
        run_op(1'b0, 5'd16, 16'h0000, 1'b0, cyc);
        expect_mem("t4_s0", exp4);
        run_op(1'b1, 5'd16, 16'h0000, 1'b0, cyc);
        expect_mem("t4_s0_inv", ident16);

        // 5: reset while in SWAP aborts immediately
        load_mem(8'h80);
        mode  = 1'b0;
        len   = 5'd8;
        seed  = 16'hACE1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("t5_busy_in_swap", busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("t5_busy_after_rst", busy, 0);
        check("t5_done_after_rst", done, 0);
        @(posedge clk);
        #1;
        check("t5_no_done_pulse", done, 0);
        load_mem(8'h80);
        run_op(1'b0, 5'd8, 16'hACE1, 1'b0, cyc);
        check("t5_rerun_cycles", cyc, 22);
        expect_mem("t5_rerun", exp1);

        // 6: host write and start while busy are ignored
        load_mem(8'h80);
        run_op(1'b0, 5'd8, 16'hACE1, 1'b1, cyc);
        check("t6_cycles", cyc, 22);
        check("t6_idle_after", busy, 0);
        expect_mem("t6", exp1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
